timer_readout: RTL and testbench
================================

// Module: timer_readout
// PURPOSE
//  Reads the game timer's remaining-frame count and converts it to M:SS decimal digits for the HUD renderer.
//  Uses a sequential repeated-subtraction divider: one subtract per clk, so no hardware dividers are needed.
//  Runs on request (once per frame from the HUD) with a busy/valid handshake. Seconds round up (ceil).
//  The display therefore shows 0:00 only when the count is exactly 0.
// PARAMETERS
//  VAL_W     14   width of timer_val input (frames remaining)
//  FPS       60   timer ticks per second (frames per displayed second)
//  WARN_SEC  10   low-time warning threshold in seconds (used only with TIMER_READOUT_WARN_EN)
// PORTS
//  clk        in   1      system clock; the only clock
//  reset      in   1      asynchronous, active-low reset (asserted when 0)
//  timer_val  in   VAL_W  frames remaining, from game timer
//  conv_req   in   1      single-cycle conversion request
//  busy       out  1      conversion in progress
//  valid      out  1      one-cycle pulse: new digits are valid this cycle
//  min_dig    out  4      minutes digit 0-9
//  sec_tens   out  4      seconds tens digit 0-5
//  sec_ones   out  4      seconds ones digit 0-9
//  warn       out  1      low-time warning (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; busy=0; valid=0; pending=0; min_dig=sec_tens=sec_ones=0; warn=0.
//  FSM: IDLE -> DIV_F -> DIV_M -> DIV_T -> DONE -> IDLE, or DONE -> DIV_F if pending.
//  IDLE: on conv_req=1, latch timer_val into rem, clear quotients, set busy=1, and go to DIV_F next cycle.
//  DIV_F: if rem>=FPS, then rem-=FPS and secs+=1, staying in DIV_F.
//   Otherwise secs+=(rem!=0), which is the ceil adjust, and go to DIV_M.
//  DIV_M: if secs>=60, then secs-=60 and mins+=1; otherwise go to DIV_T.
//  DIV_T: if secs>=10, then secs-=10 and tens+=1; otherwise go to DONE.
//  DONE: load min_dig/sec_tens/sec_ones from mins/tens/secs and pulse valid for exactly 1 cycle.
//   Update warn in the same cycle. If pending is clear, set busy=0 and go to IDLE.
//  Digits are registered and hold their value between valid pulses. The renderer may read them at any time.
//  Latency from the accept cycle to the valid cycle = (q_f+1)+(q_m+1)+(q_t+1)+1.
//   q_f = floor(timer_val/FPS), q_m = minutes, q_t = seconds tens.
//   timer_val=0 gives 4 cycles. timer_val=10800 gives 187 cycles.
//  conv_req while busy is not dropped. It sets pending=1; repeated requests collapse into one.
//   In DONE with pending=1: clear pending, relatch the current timer_val, keep busy=1, and go to DIV_F.
//  conv_req in the same cycle as DONE counts as a request while busy, so it causes a restart.
//  Minutes saturate: if mins would exceed 9, the outputs show 9:59.
//  secs/mins counters are sized VAL_W bits, so no wrap is possible.
//  timer_val changing during a conversion has no effect; only the latched copy is used.
//  Reset during a conversion aborts it immediately, with no valid pulse, and outputs return to their reset values.
// CONFIGURATION
//  Macro TIMER_READOUT_WARN_EN:
//   Defined: in DONE, warn is set to 1 when 0 < total_secs <= WARN_SEC, otherwise 0.
//    total_secs is the ceil value before minute/tens splitting. warn holds until the next DONE.
//   Undefined: warn is tied to 0. No comparator or total_secs register is built. The port list is unchanged.
// TESTING
//  T1 reset: drive reset=0 mid-DIV_F with timer_val=10800 -> busy=0, valid never pulses, digits 0:00, warn=0.
//  T2 timer_val=10800, conv_req 1 cycle -> valid 187 cycles later; digits 3:00; busy low the next cycle.
//  T3 timer_val=3599 -> 1:00 (ceil), latency 64. timer_val=1 -> 0:01, latency 4. timer_val=0 -> 0:00, latency 4.
//  T4 timer_val=600 and conv_req, then 3 more conv_req while busy and timer_val changed to 540 -> first valid shows 0:10.
//   A second conversion follows with no IDLE cycle; its valid shows 0:09. No third conversion occurs.
//  T5 with TIMER_READOUT_WARN_EN: 600 -> warn=1, 660 -> warn=0, 0 -> warn=0. Without the macro: warn=0 for all three.
//  T6 sweep timer_val 0..10800 step 1 -> digits match a ceil(v/60) M:SS reference model; sec_tens<=5 always.

Source files
------------

// File: rtl/timer_readout.sv
`default_nettype none
// ============================================================================
//  Module   : timer_readout
//  Purpose  : Converts the game timer's remaining-frame count into M:SS
//             decimal digits for the HUD. Frames are turned into seconds
//             (rounded up), then split into minutes, seconds-tens and
//             seconds-ones by repeated subtraction, one subtract per clock.
//  Options  : TIMER_READOUT_WARN_EN - when defined, builds the low-time
//             warning comparator; otherwise warn is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_readout #(
  parameter int VAL_W    = 14,
  parameter int FPS      = 60,
  parameter int WARN_SEC = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] timer_val,
  input  logic             conv_req,
  output logic             busy,
  output logic             valid,
  output logic [3:0]       min_dig,
  output logic [3:0]       sec_tens,
  output logic [3:0]       sec_ones,
  output logic             warn
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIV_F = 3'd1,
    S_DIV_M = 3'd2,
    S_DIV_T = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [VAL_W-1:0] FPS_V = VAL_W'(FPS);
  localparam logic [VAL_W-1:0] SIXTY = VAL_W'(60);
  localparam logic [VAL_W-1:0] TEN   = VAL_W'(10);
  localparam logic [VAL_W-1:0] NINE  = VAL_W'(9);
  localparam logic [VAL_W-1:0] ONE   = VAL_W'(1);

  state_t           state_q;
  logic [VAL_W-1:0] rem_q;      // frames still to be divided
  logic [VAL_W-1:0] secs_q;     // seconds, later reduced to the ones digit
  logic [VAL_W-1:0] mins_q;     // whole minutes (may exceed 9; saturated on output)
  logic [3:0]       tens_q;     // seconds tens, never above 5
  logic             pending_q;  // a request arrived while busy
  logic             busy_q;
  logic             valid_q;
  logic [3:0]       min_q;
  logic [3:0]       tens_dig_q;
  logic [3:0]       ones_q;

  // Seconds after the frame division: a partial second left in rem rounds up
  logic [VAL_W-1:0] w_secs_ceil;
  assign w_secs_ceil = secs_q + VAL_W'(rem_q != '0);

`ifdef TIMER_READOUT_WARN_EN
  localparam logic [VAL_W-1:0] WARN_V = VAL_W'(WARN_SEC);
  logic [VAL_W-1:0] total_q;    // rounded-up seconds before minute/tens split
  logic             warn_q;
`endif

  // Conversion sequencer: request capture, division steps and digit load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      secs_q     <= '0;
      mins_q     <= '0;
      tens_q     <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      min_q      <= '0;
      tens_dig_q <= '0;
      ones_q     <= '0;
`ifdef TIMER_READOUT_WARN_EN
      total_q    <= '0;
      warn_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (conv_req) begin
            rem_q   <= timer_val;
            secs_q  <= '0;
            mins_q  <= '0;
            tens_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_DIV_F;
          end
        end

        S_DIV_F: begin
          if (conv_req) pending_q <= 1'b1;
          if (rem_q >= FPS_V) begin
            rem_q  <= rem_q - FPS_V;
            secs_q <= secs_q + ONE;
          end else begin
            secs_q  <= w_secs_ceil;
`ifdef TIMER_READOUT_WARN_EN
            total_q <= w_secs_ceil;
`endif
            state_q <= S_DIV_M;
          end
        end

        S_DIV_M: begin
          if (conv_req) pending_q <= 1'b1;
          if (secs_q >= SIXTY) begin
            secs_q <= secs_q - SIXTY;
            mins_q <= mins_q + ONE;
          end else begin
            state_q <= S_DIV_T;
          end
        end

        S_DIV_T: begin
          if (conv_req) pending_q <= 1'b1;
          if (secs_q >= TEN) begin
            secs_q <= secs_q - TEN;
            tens_q <= tens_q + 4'd1;
          end else begin
            // Digits and valid are loaded on entry so they are visible in DONE
            valid_q <= 1'b1;
            if (mins_q > NINE) begin
              min_q      <= 4'd9;
              tens_dig_q <= 4'd5;
              ones_q     <= 4'd9;
            end else begin
              min_q      <= mins_q[3:0];
              tens_dig_q <= tens_q;
              ones_q     <= secs_q[3:0];
            end
`ifdef TIMER_READOUT_WARN_EN
            warn_q  <= (total_q != '0) && (total_q <= WARN_V);
`endif
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          // A request seen now or earlier in the conversion restarts at once
          if (pending_q || conv_req) begin
            pending_q <= 1'b0;
            rem_q     <= timer_val;
            secs_q    <= '0;
            mins_q    <= '0;
            tens_q    <= '0;
            state_q   <= S_DIV_F;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign min_dig  = min_q;
  assign sec_tens = tens_dig_q;
  assign sec_ones = ones_q;

`ifdef TIMER_READOUT_WARN_EN
  assign warn = warn_q;
`else
  // Warning not built; the threshold is referenced only so both builds
  // share one parameter list. Always evaluates to 0.
  assign warn = (WARN_SEC < 0) ? 1'b0 : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_readout.sv
`timescale 1ns/1ps
module tb_timer_readout;

`ifdef TIMER_READOUT_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        conv_req  = 1'b0;
  logic [13:0] timer_val = '0;
  logic        busy, valid, warn;
  logic [3:0]  min_dig, sec_tens, sec_ones;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  timer_readout #(.VAL_W(14), .FPS(60), .WARN_SEC(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .timer_val(timer_val),
    .conv_req (conv_req),
    .busy     (busy),
    .valid    (valid),
    .min_dig  (min_dig),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .warn     (warn)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic int ceil_secs(input int v);
    return (v + 59) / 60;
  endfunction

  function automatic logic [11:0] exp_digits(input int v);
    int s, m;
    s = ceil_secs(v);
    m = s / 60;
    if (m > 9) return 12'h959;
    return {4'(m), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic bit exp_warn(input int v);
    int s;
    s = ceil_secs(v);
    return WARN_ON && (s > 0) && (s <= 10);
  endfunction

  function automatic int exp_lat(input int v);
    int s;
    s = ceil_secs(v);
    return (v / 60 + 1) + (s / 60 + 1) + ((s % 60) / 10 + 1) + 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- handshake model ----------------
  // Tracks each conversion by its expected latency; DONE is the cycle
  // where the latency count is reached.
  bit          m_busy = 0, m_valid = 0, m_warn = 0, m_pend = 0;
  logic [11:0] m_dig = '0;
  int          m_t = 0, m_lat = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_valid <= 0; m_warn <= 0; m_pend <= 0;
      m_dig <= '0; m_t <= 0; m_lat <= 0;
    end else begin
      m_valid <= 0;
      if (!m_busy) begin
        if (conv_req) begin
          m_busy <= 1; m_t <= 1; m_lat <= exp_lat(int'(timer_val)); m_pend <= 0;
        end
      end else if (m_t == m_lat) begin
        if (m_pend || conv_req) begin
          m_t <= 1; m_lat <= exp_lat(int'(timer_val)); m_pend <= 0;
        end else begin
          m_busy <= 0;
        end
      end else begin
        if (conv_req) m_pend <= 1;
        m_t <= m_t + 1;
      end
    end
  end

  // Digits of the conversion in flight, captured with its request
  int m_v = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_v <= 0;
    else if ((!m_busy && conv_req) || (m_busy && m_t == m_lat && (m_pend || conv_req)))
      m_v <= int'(timer_val);
  end

  always @(posedge clk) begin
    if (reset && m_busy && m_t != m_lat && m_t + 1 == m_lat) begin
      m_valid <= 1;
      m_dig   <= exp_digits(m_v);
      m_warn  <= exp_warn(m_v);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",   int'(busy),  int'(m_busy));
      chk("cyc_valid",  int'(valid), int'(m_valid));
      chk("cyc_digits", int'({min_dig, sec_tens, sec_ones}), int'(m_dig));
      chk("cyc_warn",   int'(warn),  int'(m_warn));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic do_conv(input int v, input logic [11:0] edig, input bit ew,
                         input int elat, input string nm);
    int n;
    wait_idle(nm);
    timer_val = 14'(v);
    conv_req  = 1'b1;
    @(negedge clk);
    conv_req  = 1'b0;
    n = 1;
    while (!valid && n < 400) begin @(negedge clk); n++; end
    chk({nm, "_lat"},    n, elat);
    chk({nm, "_digits"}, int'({min_dig, sec_tens, sec_ones}), int'(edig));
    chk({nm, "_warn"},   int'(warn), int'(ew));
    chk({nm, "_tens_le5"}, int'(sec_tens <= 4'd5), 1);
    @(negedge clk);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  int bnd[] = '{59, 60, 61, 119, 120, 121, 599, 600, 601, 659, 660, 3539,
                3540, 3541, 3600, 3601, 10740, 10741, 10799, 16383};

  initial begin
    int n, cnt;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_valid",  int'(valid), 0);
    chk("rst_digits", int'({min_dig, sec_tens, sec_ones}), 0);
    chk("rst_warn",   int'(warn), 0);
    @(negedge clk);
    reset = 1'b1;

    // T3: rounding up and minimal latency
    do_conv(3599, 12'h100, 1'b0,    64, "t3_3599");
    do_conv(1,    12'h001, WARN_ON,  4, "t3_1");
    do_conv(0,    12'h000, 1'b0,     4, "t3_0");
    // T2: longest regular value
    do_conv(10800, 12'h300, 1'b0,  187, "t2_10800");
    do_conv(16383, 12'h434, 1'b0,  284, "max_16383");

    // T1: reset during the frame division
    wait_idle("t1");
    timer_val = 14'd10800;
    conv_req  = 1'b1;
    @(negedge clk);
    conv_req  = 1'b0;
    repeat (20) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t1_busy",   int'(busy), 0);
    chk("t1_valid",  int'(valid), 0);
    chk("t1_digits", int'({min_dig, sec_tens, sec_ones}), 0);
    chk("t1_warn",   int'(warn), 0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (200) begin @(negedge clk); if (valid) cnt++; end
    chk("t1_no_valid", cnt, 0);

    // T4: requests while busy collapse into a single back-to-back restart
    wait_idle("t4");
    timer_val = 14'd600;
    conv_req  = 1'b1;
    @(negedge clk);
    conv_req  = 1'b0;
    timer_val = 14'd540;
    n = 1;
    while (!valid && n < 400) begin
      conv_req = (n == 2 || n == 5 || n == 8);
      @(negedge clk);
      n++;
    end
    conv_req = 1'b0;
    chk("t4_lat1",    n, 15);
    chk("t4_digits1", int'({min_dig, sec_tens, sec_ones}), 12'h010);
    chk("t4_warn1",   int'(warn), int'(WARN_ON));
    n = 0;
    cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (!busy) cnt++;
    end while (!valid && n < 400);
    chk("t4_lat2",      n, 13);
    chk("t4_busy_gap",  cnt, 0);
    chk("t4_digits2",   int'({min_dig, sec_tens, sec_ones}), 12'h009);
    chk("t4_warn2",     int'(warn), int'(WARN_ON));
    @(negedge clk);
    chk("t4_busy_end",  int'(busy), 0);
    cnt = 0;
    repeat (30) begin @(negedge clk); if (valid) cnt++; end
    chk("t4_no_third", cnt, 0);

    // T5: warning threshold
    do_conv(600, 12'h010, WARN_ON, 15, "t5_600");
    do_conv(660, 12'h011, 1'b0,    16, "t5_660");
    do_conv(0,   12'h000, 1'b0,     4, "t5_0");

    // T6: sampled sweep plus boundary values
    for (int v = 0; v <= 10800; v += 113)
      do_conv(v, exp_digits(v), exp_warn(v), exp_lat(v), "sweep");
    foreach (bnd[i])
      do_conv(bnd[i], exp_digits(bnd[i]), exp_warn(bnd[i]), exp_lat(bnd[i]), "bound");

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
